// File: rtl/vga_scan_reader.sv
// vga_scan_reader: display-side scanner for the 3-bit RGB video memory.
// It divides the system clock down to the pixel rate and generates 640x480@60
// timing. It issues row-major linear read addresses for active pixels, then
// registers the returned colour together with the syncs of the same pixel.
//
// Pipeline per pixel tick:
//   stage 0: decode (hcount, vcount) into active/hsync/vsync and step the read address
//   stage 1: take memory data for the stage-0 pixel and drive syncs and colour
// oFrameStart pulses for one clock, together with oReadAddress returning to 0,
// on the tick that registers pixel (0,0) of a frame.
module vga_scan_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int ADDR_W   = 24
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iEnable,
    output logic [ADDR_W-1:0] oReadAddress,
    input  logic [2:0]        iReadData,
    output logic              oVGA_HSYNC,
    output logic              oVGA_VSYNC,
    output logic              oVGA_R,
    output logic              oVGA_G,
    output logic              oVGA_B,
    output logic              oFrameStart
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START  = H_ACTIVE + H_FP;
    localparam int HS_END    = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START  = V_ACTIVE + V_FP;
    localparam int VS_END    = V_ACTIVE + V_FP + V_SYNC;
    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HCNT_W    = $clog2(H_TOTAL);
    localparam int VCNT_W    = $clog2(V_TOTAL);

    // Divider and raster counters
    logic [DIV_W-1:0]  div_q,    div_d;
    logic [HCNT_W-1:0] hcount_q, hcount_d;
    logic [VCNT_W-1:0] vcount_q, vcount_d;

    // Stage 0: decoded pixel attributes and read address
    logic              active0_q, active0_d;
    logic              hs0_q,     hs0_d;
    logic              vs0_q,     vs0_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;

    // Stage 1: registered outputs
    logic              hsync_q,   hsync_d;
    logic              vsync_q,   vsync_d;
    logic [2:0]        rgb_q,     rgb_d;
    logic              fstart_q,  fstart_d;

    // Decode of the current raster position
    logic tick;
    logic h_last;
    logic v_last;
    logic active_now;
    logic hs_now;
    logic vs_now;
    logic frame_origin;

    assign tick         = (div_q == DIV_W'(CLK_DIV - 1));
    assign h_last       = (hcount_q == HCNT_W'(H_TOTAL - 1));
    assign v_last       = (vcount_q == VCNT_W'(V_TOTAL - 1));
    assign active_now   = (hcount_q < HCNT_W'(H_ACTIVE)) && (vcount_q < VCNT_W'(V_ACTIVE));
    assign hs_now       = !((hcount_q >= HCNT_W'(HS_START)) && (hcount_q < HCNT_W'(HS_END)));
    assign vs_now       = !((vcount_q >= VCNT_W'(VS_START)) && (vcount_q < VCNT_W'(VS_END)));
    assign frame_origin = (hcount_q == '0) && (vcount_q == '0);

    // Next-state: pixel divider and raster counters, cleared while disabled
    always_comb begin
        div_d    = div_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (!iEnable) begin
            div_d    = '0;
            hcount_d = '0;
            vcount_d = '0;
        end else if (tick) begin
            div_d = '0;
            if (h_last) begin
                hcount_d = '0;
                vcount_d = v_last ? '0 : vcount_q + VCNT_W'(1);
            end else begin
                hcount_d = hcount_q + HCNT_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Next-state: two-stage pixel pipeline and frame-start pulse
    always_comb begin
        active0_d = active0_q;
        hs0_d     = hs0_q;
        vs0_d     = vs0_q;
        addr_d    = addr_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        rgb_d     = rgb_q;
        fstart_d  = 1'b0;
        if (!iEnable) begin
            active0_d = 1'b0;
            hs0_d     = 1'b1;
            vs0_d     = 1'b1;
            addr_d    = '0;
            hsync_d   = 1'b1;
            vsync_d   = 1'b1;
            rgb_d     = 3'b000;
        end else if (tick) begin
            // Active pixels are contiguous in memory, so the address only
            // needs an increment; the frame origin re-anchors it at 0.
            active0_d = active_now;
            hs0_d     = hs_now;
            vs0_d     = vs_now;
            if (active_now) begin
                addr_d = frame_origin ? '0 : addr_q + ADDR_W'(1);
            end
            // Memory data for the stage-0 pixel has had CLK_DIV clocks to settle.
            hsync_d   = hs0_q;
            vsync_d   = vs0_q;
            rgb_d     = active0_q ? iReadData : 3'b000;
            fstart_d  = frame_origin;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            div_q     <= '0;
            hcount_q  <= '0;
            vcount_q  <= '0;
            active0_q <= 1'b0;
            hs0_q     <= 1'b1;
            vs0_q     <= 1'b1;
            addr_q    <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            rgb_q     <= 3'b000;
            fstart_q  <= 1'b0;
        end else begin
            div_q     <= div_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            active0_q <= active0_d;
            hs0_q     <= hs0_d;
            vs0_q     <= vs0_d;
            addr_q    <= addr_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            rgb_q     <= rgb_d;
            fstart_q  <= fstart_d;
        end
    end

    assign oReadAddress = addr_q;
    assign oVGA_HSYNC   = hsync_q;
    assign oVGA_VSYNC   = vsync_q;
    assign oVGA_R       = rgb_q[2];
    assign oVGA_G       = rgb_q[1];
    assign oVGA_B       = rgb_q[0];
    assign oFrameStart  = fstart_q;

endmodule

// File: tb/tb_vga_scan_reader.sv
// Testbench for vga_scan_reader using a reduced raster geometry so that
// several whole frames fit in a short run. Expected outputs are computed from
// the number of enabled clocks since the last restart: k pixel ticks have
// happened, stage 0 holds pixel k-1 and the outputs show pixel k-2.
module tb_vga_scan_reader;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int CDIV = 2;
    localparam int ADDR_W = 24;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              iEnable;
    logic [ADDR_W-1:0] oReadAddress;
    logic [2:0]        iReadData = 3'b000;
    logic              oVGA_HSYNC, oVGA_VSYNC, oVGA_R, oVGA_G, oVGA_B, oFrameStart;

    logic [2:0] mem [0:63];
    int e;
    int n_tests = 0;
    int n_fail  = 0;

    vga_scan_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(CDIV), .ADDR_W(ADDR_W)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iEnable(iEnable),
        .oReadAddress(oReadAddress), .iReadData(iReadData),
        .oVGA_HSYNC(oVGA_HSYNC), .oVGA_VSYNC(oVGA_VSYNC),
        .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oFrameStart(oFrameStart)
    );

    always #5 Clock = ~Clock;

    // Video memory model: one clock of read latency
    always @(posedge Clock) iReadData <= mem[oReadAddress[5:0]];

    // Address of the most recent active pixel at or before raster pixel p
    function automatic int last_addr(input int p);
        int f, h, v;
        f = p % FR;
        h = f % HT;
        v = f / HT;
        if (v >= VA) return VA * HA - 1;
        if (h >= HA) return v * HA + HA - 1;
        return v * HA + h;
    endfunction

    task automatic check_outputs(input string tag);
        int k, p, f, h, v;
        logic [ADDR_W-1:0] ea;
        logic ehs, evs, efs;
        logic [2:0] ergb;
        k    = e / CDIV;
        ea   = (k == 0) ? '0 : ADDR_W'(last_addr(k - 1));
        ehs  = 1'b1;
        evs  = 1'b1;
        ergb = 3'b000;
        if (k >= 2) begin
            p = k - 2;
            f = p % FR;
            h = f % HT;
            v = f / HT;
            ehs = !(h >= HA + HF && h < HA + HF + HS);
            evs = !(v >= VA + VF && v < VA + VF + VS);
            if (h < HA && v < VA) ergb = mem[(v * HA + h) % 64];
        end
        efs = (e % CDIV == 0) && (k >= 1) && ((k - 1) % FR == 0);

        n_tests++;
        assert (oReadAddress === ea) else begin
            n_fail++;
            $error("FAIL %s addr: got %0d expected %0d (clk %0d)", tag, oReadAddress, ea, e);
        end
        n_tests++;
        assert (oVGA_HSYNC === ehs) else begin
            n_fail++;
            $error("FAIL %s hsync: got %b expected %b (clk %0d)", tag, oVGA_HSYNC, ehs, e);
        end
        n_tests++;
        assert (oVGA_VSYNC === evs) else begin
            n_fail++;
            $error("FAIL %s vsync: got %b expected %b (clk %0d)", tag, oVGA_VSYNC, evs, e);
        end
        n_tests++;
        assert ({oVGA_R, oVGA_G, oVGA_B} === ergb) else begin
            n_fail++;
            $error("FAIL %s rgb: got %b expected %b (clk %0d)", tag, {oVGA_R, oVGA_G, oVGA_B}, ergb, e);
        end
        n_tests++;
        assert (oFrameStart === efs) else begin
            n_fail++;
            $error("FAIL %s framestart: got %b expected %b (clk %0d)", tag, oFrameStart, efs, e);
        end
    endtask

    // One clock: track enabled clocks since restart, then check on the falling edge
    task automatic step(input string tag);
        @(posedge Clock);
        if (!Reset && iEnable) e++;
        else e = 0;
        @(negedge Clock);
        check_outputs(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        Reset   = 1'b1;
        iEnable = 1'b0;
        e       = 0;
        for (int i = 0; i < 64; i++) mem[i] = 3'b101;

        // Reset state
        run(3, "reset");
        Reset = 1'b0;
        run(2, "idle");

        // Constant colour over two full frames
        iEnable = 1'b1;
        run(2 * FR * CDIV + 20, "const");

        // Random memory contents under reset, then a full frame and a half
        Reset = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 3'($urandom);
        run(2, "reset2");
        Reset = 1'b0;
        run(FR * CDIV + FR, "random");

        // Enable dropped mid-frame for 10 clocks, then restart
        iEnable = 1'b0;
        run(10, "disabled");
        iEnable = 1'b1;
        run(FR * CDIV + 10, "reenable");

        // Asynchronous reset between clock edges
        for (int r = 0; r < 3; r++) begin
            run($urandom_range(20, 250), "pre_areset");
            #1;
            Reset = 1'b1;
            #1;
            e = 0;
            check_outputs("areset_noclk");
            run(2, "areset_hold");
            Reset = 1'b0;
            run($urandom_range(FR * CDIV, FR * CDIV + 60), "post_areset");
        end

        // Random short enable drops
        for (int r = 0; r < 4; r++) begin
            iEnable = 1'b0;
            run($urandom_range(1, 12), "rnd_off");
            iEnable = 1'b1;
            run($urandom_range(30, 400), "rnd_on");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
